cmd_dispatch_multich: RTL and testbench



---
 rtl/cmd_dispatch_multich_if.sv | 41 ++++
 rtl/cmd_dispatch_multich.sv | 195 +++++++++++++++++++
 tb/tb_cmd_dispatch_multich.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_multich_if.sv
// Bundle of command, response, SPI, capture and config signals around the dispatcher.
// master = the dispatcher itself, slave = the surrounding UART/SPI/capture logic.
interface cmd_dispatch_multich_if #(
    parameter int NUM_CH = 3,
    parameter int POS_W  = 9
);
    logic [23:0]         cmd;
    logic                cmd_rdy;
    logic                clr_cmd_rdy;
    logic [7:0]          resp_data;
    logic                send_resp;
    logic                resp_sent;
    logic [NUM_CH+1:0]   ss;
    logic                wrt_SPI;
    logic [15:0]         SPI_data;
    logic                SPI_done;
    logic [7:0]          EEP_data;
    logic                start_dump;
    logic [2:0]          dump_channel;
    logic                dump_rdy;
    logic                send_dump;
    logic [7:0]          dump_data;
    logic                dump_finished;
    logic [5:0]          trig_cfg;
    logic [3:0]          decimator;
    logic [POS_W-1:0]    trig_pos;

    modport master (
        input  cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
               send_dump, dump_data, dump_finished,
        output clr_cmd_rdy, resp_data, send_resp, ss, wrt_SPI, SPI_data,
               start_dump, dump_channel, dump_rdy, trig_cfg, decimator, trig_pos
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
               send_dump, dump_data, dump_finished,
        input  clr_cmd_rdy, resp_data, send_resp, ss, wrt_SPI, SPI_data,
               start_dump, dump_channel, dump_rdy, trig_cfg, decimator, trig_pos
    );
endinterface

// File: rtl/cmd_dispatch_multich.sv
// Command dispatcher: decodes 24-bit commands into config writes, one-hot SPI
// transactions with timeout, and a flow-controlled capture dump path.
module cmd_dispatch_multich #(
    parameter int NUM_CH = 3,
    parameter int POS_W  = 9,
    parameter int SPI_TO = 1024
) (
    input logic                    clk,
    input logic                    rst_n,
    cmd_dispatch_multich_if.master bus
);
    localparam int SS_W  = NUM_CH + 2;
    localparam int CNT_W = $clog2(SPI_TO + 1);
    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;
    localparam logic [SS_W-1:0] SS_TRIG = SS_W'(1) << NUM_CH;
    localparam logic [SS_W-1:0] SS_EEP  = SS_W'(1) << (NUM_CH + 1);

    typedef enum logic [2:0] {IDLE, SPI_WAIT, EEP_RD1, EEP_RD2, DUMP, WAIT_RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] to_cnt;
    logic             dump_pend;
    logic             fin_latch;

    logic [7:0] opcode;
    logic [2:0] ch;
    logic       ch_bad;
    logic       timed_out;
    logic       imm_resp;
    logic [7:0] imm_byte;

    function automatic logic [7:0] gain_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    gain_lut = 8'h02;
            3'd1:    gain_lut = 8'h05;
            3'd2:    gain_lut = 8'h09;
            3'd3:    gain_lut = 8'h14;
            3'd4:    gain_lut = 8'h28;
            3'd5:    gain_lut = 8'h46;
            3'd6:    gain_lut = 8'h6B;
            default: gain_lut = 8'hDD;
        endcase
    endfunction

    assign opcode    = bus.cmd[23:16];
    assign ch        = bus.cmd[10:8];
    assign ch_bad    = int'(ch) >= NUM_CH;
    assign timed_out = (to_cnt == CNT_W'(SPI_TO));

    // Commands answered straight from IDLE (ACK, NACK or a register readback).
    always_comb begin
        imm_resp = 1'b1;
        imm_byte = NACK;
        case (opcode)
            8'h01, 8'h02:        imm_resp = ch_bad;
            8'h03, 8'h08, 8'h09: imm_resp = 1'b0;
            8'h04, 8'h05, 8'h06: imm_byte = ACK;
            8'h07:               imm_byte = {2'b00, bus.trig_cfg};
            default:             imm_byte = NACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            to_cnt           <= '0;
            dump_pend        <= 1'b0;
            fin_latch        <= 1'b0;
            bus.clr_cmd_rdy  <= 1'b0;
            bus.resp_data    <= '0;
            bus.send_resp    <= 1'b0;
            bus.ss           <= '0;
            bus.wrt_SPI      <= 1'b0;
            bus.SPI_data     <= '0;
            bus.start_dump   <= 1'b0;
            bus.dump_channel <= '0;
            bus.dump_rdy     <= 1'b0;
            bus.trig_cfg     <= '0;
            bus.decimator    <= '0;
            bus.trig_pos     <= '0;
        end else begin
            bus.clr_cmd_rdy <= 1'b0;
            bus.send_resp   <= 1'b0;
            bus.wrt_SPI     <= 1'b0;
            bus.start_dump  <= 1'b0;

            case (state)
                IDLE: if (bus.cmd_rdy) begin
                    bus.clr_cmd_rdy <= 1'b1;
                    if (imm_resp) begin
                        bus.resp_data <= imm_byte;
                        bus.send_resp <= 1'b1;
                        state         <= WAIT_RESP;
                    end
                    case (opcode)
                        8'h01: if (!ch_bad) begin
                            bus.dump_channel <= ch;
                            bus.start_dump   <= 1'b1;
                            bus.dump_rdy     <= 1'b1;
                            dump_pend        <= 1'b0;
                            fin_latch        <= 1'b0;
                            state            <= DUMP;
                        end
                        8'h02: if (!ch_bad) begin
                            bus.SPI_data <= {8'h13, gain_lut(bus.cmd[14:12])};
                            bus.ss       <= SS_W'(1) << ch;
                            bus.wrt_SPI  <= 1'b1;
                            to_cnt       <= '0;
                            state        <= SPI_WAIT;
                        end
                        8'h03: begin
                            bus.SPI_data <= {8'h13, bus.cmd[7:0]};
                            bus.ss       <= SS_TRIG;
                            bus.wrt_SPI  <= 1'b1;
                            to_cnt       <= '0;
                            state        <= SPI_WAIT;
                        end
                        8'h04: bus.trig_pos  <= bus.cmd[POS_W-1:0];
                        8'h05: bus.decimator <= bus.cmd[3:0];
                        8'h06: bus.trig_cfg  <= bus.cmd[13:8];
                        8'h08: begin
                            bus.SPI_data <= {2'b01, bus.cmd[13:0]};
                            bus.ss       <= SS_EEP;
                            bus.wrt_SPI  <= 1'b1;
                            to_cnt       <= '0;
                            state        <= SPI_WAIT;
                        end
                        8'h09: begin
                            bus.SPI_data <= {2'b00, bus.cmd[13:8], 8'h00};
                            bus.ss       <= SS_EEP;
                            bus.wrt_SPI  <= 1'b1;
                            to_cnt       <= '0;
                            state        <= EEP_RD1;
                        end
                        default: ;
                    endcase
                end

                // SPI_done is checked before the timeout so a late completion still wins.
                SPI_WAIT, EEP_RD1, EEP_RD2: begin
                    if (bus.SPI_done) begin
                        if (state == EEP_RD1) begin
                            bus.wrt_SPI  <= 1'b1;
                            bus.SPI_data <= 16'h0000;
                            to_cnt       <= '0;
                            state        <= EEP_RD2;
                        end else begin
                            bus.ss        <= '0;
                            bus.resp_data <= (state == EEP_RD2) ? bus.EEP_data : ACK;
                            bus.send_resp <= 1'b1;
                            state         <= WAIT_RESP;
                        end
                    end else if (timed_out) begin
                        bus.ss        <= '0;
                        bus.resp_data <= NACK;
                        bus.send_resp <= 1'b1;
                        state         <= WAIT_RESP;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end

                // One byte in flight at a time; exit only once the finish latch is set
                // and the last forwarded byte has been acknowledged.
                DUMP: begin
                    if (bus.dump_finished) fin_latch <= 1'b1;
                    if (bus.send_dump && !dump_pend) begin
                        bus.resp_data <= bus.dump_data;
                        bus.send_resp <= 1'b1;
                        bus.dump_rdy  <= 1'b0;
                        dump_pend     <= 1'b1;
                    end else if (dump_pend && bus.resp_sent) begin
                        dump_pend <= 1'b0;
                        if (fin_latch || bus.dump_finished) begin
                            bus.dump_rdy <= 1'b0;
                            fin_latch    <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            bus.dump_rdy <= 1'b1;
                        end
                    end else if (!dump_pend && (fin_latch || bus.dump_finished)) begin
                        bus.dump_rdy <= 1'b0;
                        fin_latch    <= 1'b0;
                        state        <= IDLE;
                    end
                end

                WAIT_RESP: if (bus.resp_sent) state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_dispatch_multich.sv
// Randomized bench for cmd_dispatch_multich against a transaction-level reference model.
module tb_cmd_dispatch_multich;
    localparam int NUM_CH = 3;
    localparam int POS_W  = 9;
    localparam int SPI_TO = 40;
    localparam int SS_W   = NUM_CH + 2;

    typedef enum {K_RESP, K_SPI, K_EEPRD, K_DUMP} kind_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_dispatch_multich_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) bus();

    cmd_dispatch_multich #(.NUM_CH(NUM_CH), .POS_W(POS_W), .SPI_TO(SPI_TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0]       m_trig_cfg;
    logic [3:0]       m_decim;
    logic [POS_W-1:0] m_trig_pos;
    logic [7:0]       gain_tab [8] = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What a command should do, derived from the opcode table; updates model registers.
    task automatic predict(input logic [23:0] c, output kind_t k, output logic [7:0] r,
                           output logic [15:0] f, output logic [SS_W-1:0] s);
        int op;
        int chn;
        op  = int'(c[23:16]);
        chn = int'(c[10:8]);
        k = K_RESP; r = 8'hEE; f = '0; s = '0;
        if ((op == 1 || op == 2) && chn >= NUM_CH) return;
        case (op)
            1: k = K_DUMP;
            2: begin k = K_SPI;   f = {8'h13, gain_tab[c[14:12]]};  s = SS_W'(1) << chn; end
            3: begin k = K_SPI;   f = {8'h13, c[7:0]};              s = SS_W'(1) << NUM_CH; end
            4: begin m_trig_pos = c[POS_W-1:0]; r = 8'hA5; end
            5: begin m_decim    = c[3:0];       r = 8'hA5; end
            6: begin m_trig_cfg = c[13:8];      r = 8'hA5; end
            7: r = {2'b00, m_trig_cfg};
            8: begin k = K_SPI;   f = {2'b01, c[13:0]};             s = SS_W'(1) << (NUM_CH + 1); end
            9: begin k = K_EEPRD; f = {2'b00, c[13:8], 8'h00};      s = SS_W'(1) << (NUM_CH + 1); end
            default: ;
        endcase
    endtask

    task automatic check_regs();
        check_eq("trig_pos", bus.trig_pos, m_trig_pos);
        check_eq("decimator", bus.decimator, m_decim);
        check_eq("trig_cfg", bus.trig_cfg, m_trig_cfg);
    endtask

    task automatic finish_resp();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.resp_sent = 1'b1;
        @(negedge clk);
        bus.resp_sent = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] eep);
        bus.SPI_done = 1'b1;
        bus.EEP_data = eep;
        @(negedge clk);
        bus.SPI_done = 1'b0;
    endtask

    task automatic run_cmd(input logic [23:0] c, input bit let_timeout);
        kind_t            k;
        logic [7:0]       r;
        logic [15:0]      f;
        logic [SS_W-1:0]  s;
        logic [7:0]       b;
        int               n, nb, dly;
        bit               together;
        predict(c, k, r, f, s);
        bus.cmd     = c;
        bus.cmd_rdy = 1'b1;
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        check_eq("clr_cmd_rdy", bus.clr_cmd_rdy, 1);
        case (k)
            K_RESP: begin
                check_eq("no wrt_SPI", bus.wrt_SPI, 0);
                check_eq("imm send_resp", bus.send_resp, 1);
                check_eq("imm resp_data", bus.resp_data, r);
                finish_resp();
            end
            K_SPI, K_EEPRD: begin
                check_eq("wrt_SPI", bus.wrt_SPI, 1);
                check_eq("SPI_data", bus.SPI_data, f);
                check_eq("ss", bus.ss, s);
                if (let_timeout) begin
                    n = 0;
                    while (bus.send_resp !== 1'b1 && n < SPI_TO + 10) begin
                        @(negedge clk);
                        n++;
                    end
                    check_eq("timeout cycles", n, SPI_TO + 1);
                    check_eq("timeout resp", bus.resp_data, 8'hEE);
                    check_eq("timeout ss", bus.ss, 0);
                end else begin
                    // cmd_rdy raised mid-transaction must not be consumed
                    bus.cmd_rdy = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    check_eq("busy no clr", bus.clr_cmd_rdy, 0);
                    bus.cmd_rdy = 1'b0;
                    check_eq("ss held", bus.ss, s);
                    pulse_done(8'h00);
                    if (k == K_EEPRD) begin
                        check_eq("rd2 wrt_SPI", bus.wrt_SPI, 1);
                        check_eq("rd2 SPI_data", bus.SPI_data, 16'h0000);
                        check_eq("rd2 ss", bus.ss, s);
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        b = 8'($urandom);
                        pulse_done(b);
                        check_eq("eep resp", bus.resp_data, b);
                    end else begin
                        check_eq("ack resp", bus.resp_data, 8'hA5);
                    end
                    check_eq("done send_resp", bus.send_resp, 1);
                    check_eq("done ss", bus.ss, 0);
                end
                finish_resp();
            end
            K_DUMP: begin
                check_eq("start_dump", bus.start_dump, 1);
                check_eq("dump_channel", bus.dump_channel, c[10:8]);
                check_eq("dump_rdy entry", bus.dump_rdy, 1);
                nb = $urandom_range(0, 4);
                together = 1'($urandom_range(0, 1));
                for (int i = 0; i < nb; i++) begin
                    check_eq("dump_rdy free", bus.dump_rdy, 1);
                    b = 8'($urandom);
                    bus.send_dump = 1'b1;
                    bus.dump_data = b;
                    if (i == nb - 1 && together) bus.dump_finished = 1'b1;
                    @(negedge clk);
                    bus.send_dump     = 1'b0;
                    bus.dump_finished = 1'b0;
                    check_eq("dump send_resp", bus.send_resp, 1);
                    check_eq("dump byte", bus.resp_data, b);
                    dly = $urandom_range(1, 5);
                    repeat (dly) @(negedge clk);
                    check_eq("dump_rdy pending", bus.dump_rdy, 0);
                    bus.resp_sent = 1'b1;
                    @(negedge clk);
                    bus.resp_sent = 1'b0;
                end
                if (!(together && nb > 0)) begin
                    bus.dump_finished = 1'b1;
                    @(negedge clk);
                    bus.dump_finished = 1'b0;
                end
                check_eq("dump exit rdy", bus.dump_rdy, 0);
            end
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] c;
        bus.cmd = '0; bus.cmd_rdy = 0; bus.resp_sent = 0; bus.SPI_done = 0;
        bus.EEP_data = '0; bus.send_dump = 0; bus.dump_data = '0; bus.dump_finished = 0;
        m_trig_cfg = '0; m_decim = '0; m_trig_pos = '0;
        repeat (3) @(negedge clk);
        check_eq("rst clr_cmd_rdy", bus.clr_cmd_rdy, 0);
        check_eq("rst send_resp", bus.send_resp, 0);
        check_eq("rst resp_data", bus.resp_data, 0);
        check_eq("rst ss", bus.ss, 0);
        check_eq("rst wrt_SPI", bus.wrt_SPI, 0);
        check_eq("rst SPI_data", bus.SPI_data, 0);
        check_eq("rst start_dump", bus.start_dump, 0);
        check_eq("rst dump_rdy", bus.dump_rdy, 0);
        check_regs();
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(24'h026200, 0);
        run_cmd(24'h020300, 0);
        run_cmd(24'h1F0000, 0);
        run_cmd(24'h092A00, 0);
        run_cmd(24'h080155, 1);
        run_cmd(24'h010100, 0);
        run_cmd(24'h0401FF, 0);
        run_cmd(24'h062D00, 0);
        run_cmd(24'h070000, 0);
        check_regs();

        for (int i = 0; i < 200; i++) begin
            c[15:0]  = 16'($urandom);
            c[23:16] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            run_cmd(c, $urandom_range(0, 7) == 0);
            check_regs();
        end

        // Reset while an SPI transaction is outstanding
        bus.cmd = 24'h030077; bus.cmd_rdy = 1'b1;
        @(negedge clk);
        bus.cmd_rdy = 1'b0;
        check_eq("pre-rst ss", bus.ss, SS_W'(1) << NUM_CH);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async rst ss", bus.ss, 0);
        m_trig_cfg = '0; m_decim = '0; m_trig_pos = '0;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(24'h070000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
